// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory between the fetch and data ports.
// The data port wins a cold start; a port completing hands the memory to the other if it is waiting.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_MEM = 2'd1,
    BUSY_IF  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;

  logic                mem_any;
  logic                mem_pend;
  logic                if_pend;

  // A port showing done is still presenting the request just served, so it must not win again.
  assign mem_any  = mem_rd | mem_wr;
  assign mem_pend = mem_any & ~mem_done_q;
  assign if_pend  = if_req & ~if_done_q;

  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_pend) begin
          state_d     = BUSY_MEM;
          ram_req_d   = 1'b1;
          ram_we_d    = mem_wr;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
        end else if (if_pend) begin
          state_d    = BUSY_IF;
          ram_req_d  = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = if_addr;
        end
      end

      BUSY_MEM: begin
        if (ram_ready) begin
          mem_done_d = 1'b1;
          if (!ram_we_q) begin
            mem_rdata_d = ram_rdata;
          end
          if (if_pend) begin
            state_d    = BUSY_IF;
            ram_we_d   = 1'b0;
            ram_addr_d = if_addr;
          end else begin
            state_d   = IDLE;
            ram_req_d = 1'b0;
          end
        end
      end

      BUSY_IF: begin
        if (ram_ready) begin
          if_done_d  = 1'b1;
          if_rdata_d = ram_rdata;
          if (mem_pend) begin
            state_d     = BUSY_MEM;
            ram_we_d    = mem_wr;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
          end else begin
            state_d   = IDLE;
            ram_req_d = 1'b0;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        ram_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;

  assign if_stall  = if_req & ~if_done_q;
  assign mem_stall = mem_any & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scenario tests for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    if_req = 0; mem_rd = 0; mem_wr = 0; ram_ready = 1;
    repeat (3) next_cycle();
    ram_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0; if_req = 1; mem_rd = 0; mem_wr = 0; ram_ready = 1;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; ram_rdata = 32'h0;
    @(negedge clk);
    n_checks++;
    if ({ram_req, ram_we, if_done, mem_done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0000", {ram_req, ram_we, if_done, mem_done});
    end
    n_checks++;
    if ({ram_addr, ram_wdata, if_rdata, mem_rdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", {ram_addr, ram_wdata, if_rdata, mem_rdata});
    end
    n_checks++;
    if ({if_stall, mem_stall} !== 2'b10) begin
      n_fail++; $display("FAIL reset_stall_if got %b want 10", {if_stall, mem_stall});
    end
    if_req = 0; mem_rd = 1; #1;
    n_checks++;
    if ({if_stall, mem_stall} !== 2'b01) begin
      n_fail++; $display("FAIL reset_stall_mem got %b want 01", {if_stall, mem_stall});
    end
    mem_rd = 0; ram_ready = 0;
    next_cycle();
    rst = 1;
    next_cycle();
  endtask

  task automatic test_zero_wait_load();
    ram_ready = 1; ram_rdata = 32'hDEADBEEF; mem_rd = 1; mem_addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_rd = 0;
      @(negedge clk);
      n_checks++;
      if (ram_req !== (c == 1) || (c == 1 && (ram_addr !== 32'h40 || ram_we !== 1'b0))) begin
        n_fail++; $display("FAIL zw_req c%0d got req=%b addr=%h we=%b", c, ram_req, ram_addr, ram_we);
      end
      n_checks++;
      if (mem_done !== (c == 2) || mem_stall !== (c < 2)) begin
        n_fail++; $display("FAIL zw_done c%0d got done=%b stall=%b", c, mem_done, mem_stall);
      end
      if (c == 2) begin
        n_checks++;
        if (mem_rdata !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL zw_rdata got %h want deadbeef", mem_rdata);
        end
      end
      next_cycle();
    end
    quiesce();
  endtask

  task automatic test_wait_store();
    ram_ready = 0; ram_rdata = 32'hBAD0BAD0;
    mem_wr = 1; mem_addr = 32'h80; mem_wdata = 32'h12345678;
    for (int c = 0; c < 7; c++) begin
      ram_ready = (c == 4);
      if (c == 6) mem_wr = 0;
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if ({ram_req, ram_we} !== 2'b11 || ram_addr !== 32'h80 || ram_wdata !== 32'h12345678) begin
          n_fail++; $display("FAIL ws_hold c%0d got req=%b we=%b addr=%h wd=%h", c, ram_req, ram_we, ram_addr, ram_wdata);
        end
      end
      n_checks++;
      if (mem_done !== (c == 5) || mem_stall !== (c < 5)) begin
        n_fail++; $display("FAIL ws_done c%0d got done=%b stall=%b", c, mem_done, mem_stall);
      end
      next_cycle();
    end
    n_checks++;
    if (mem_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL ws_rdata got %h want deadbeef", mem_rdata);
    end
    quiesce();
  endtask

  task automatic test_collision();
    ram_ready = 1;
    if_req = 1; if_addr = 32'h100; mem_rd = 1; mem_addr = 32'h200;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) ram_rdata = 32'h2222;
      if (c == 2) ram_rdata = 32'h1111;
      if (c == 3) begin mem_rd = 0; if_req = 0; end
      @(negedge clk);
      n_checks++;
      if (ram_req !== (c == 1 || c == 2)) begin
        n_fail++; $display("FAIL col_req c%0d got %b", c, ram_req);
      end
      if (c == 1 || c == 2) begin
        n_checks++;
        if (ram_addr !== ((c == 1) ? 32'h200 : 32'h100) || ram_we !== 1'b0) begin
          n_fail++; $display("FAIL col_addr c%0d got %h we=%b", c, ram_addr, ram_we);
        end
      end
      n_checks++;
      if (mem_done !== (c == 2) || if_done !== (c == 3)) begin
        n_fail++; $display("FAIL col_done c%0d got mem=%b if=%b", c, mem_done, if_done);
      end
      next_cycle();
    end
    n_checks++;
    if (mem_rdata !== 32'h2222 || if_rdata !== 32'h1111) begin
      n_fail++; $display("FAIL col_rdata got mem=%h if=%h want 2222/1111", mem_rdata, if_rdata);
    end
    quiesce();
  endtask

  task automatic test_fairness();
    int mem_run = 0;
    int if_run  = 0;
    ram_ready = 1; ram_rdata = 32'h3333;
    mem_rd = 1; mem_addr = 32'h300; if_req = 1; if_addr = 32'h400;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      mem_run = mem_stall ? mem_run + 1 : 0;
      if_run  = if_stall  ? if_run + 1  : 0;
      if (c >= 1) begin
        n_checks++;
        if (ram_req !== (c % 3 != 0) ||
            (c % 3 == 1 && ram_addr !== 32'h300) || (c % 3 == 2 && ram_addr !== 32'h400)) begin
          n_fail++; $display("FAIL fair_grant c%0d got req=%b addr=%h", c, ram_req, ram_addr);
        end
      end
      n_checks++;
      if (mem_run > 4 || if_run > 4) begin
        n_fail++; $display("FAIL fair_stall c%0d got runs mem=%0d if=%0d want <=4", c, mem_run, if_run);
      end
      next_cycle();
    end
    quiesce();
  endtask

  task automatic test_reset_mid();
    ram_ready = 0; mem_rd = 1; mem_addr = 32'h500;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (ram_req !== 1'b1) begin
      n_fail++; $display("FAIL rm_busy got req=%b want 1", ram_req);
    end
    #2 rst = 0;
    #1;
    n_checks++;
    if ({ram_req, ram_we, mem_done, if_done} !== 4'b0000 || {ram_addr, mem_rdata, if_rdata} !== 96'h0) begin
      n_fail++; $display("FAIL rm_async got req=%b we=%b addr=%h rd=%h", ram_req, ram_we, ram_addr, mem_rdata);
    end
    n_checks++;
    if (mem_stall !== 1'b1 || if_stall !== 1'b0) begin
      n_fail++; $display("FAIL rm_stall got mem=%b if=%b want 1/0", mem_stall, if_stall);
    end
    next_cycle();
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      ram_ready = (c == 1); ram_rdata = 32'h77777777;
      if (c == 3) mem_rd = 0;
      @(negedge clk);
      n_checks++;
      if (ram_req !== (c == 1) || (c == 1 && ram_addr !== 32'h500)) begin
        n_fail++; $display("FAIL rm_fresh c%0d got req=%b addr=%h", c, ram_req, ram_addr);
      end
      if (c == 2) begin
        n_checks++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h77777777) begin
          n_fail++; $display("FAIL rm_done got done=%b rd=%h want 1/77777777", mem_done, mem_rdata);
        end
      end
      next_cycle();
    end
    quiesce();
  endtask

  task automatic test_rw_conflict();
    ram_ready = 1; ram_rdata = 32'h55555555;
    mem_rd = 1; mem_wr = 1; mem_addr = 32'h600; mem_wdata = 32'hCAFEF00D;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin mem_rd = 0; mem_wr = 0; end
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if ({ram_req, ram_we} !== 2'b11 || ram_wdata !== 32'hCAFEF00D || ram_addr !== 32'h600) begin
          n_fail++; $display("FAIL rw_we got req=%b we=%b wd=%h addr=%h", ram_req, ram_we, ram_wdata, ram_addr);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h77777777) begin
          n_fail++; $display("FAIL rw_rdata got done=%b rd=%h want 1/77777777", mem_done, mem_rdata);
        end
      end
      next_cycle();
    end
    quiesce();
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_wait_store();
    test_collision();
    test_fairness();
    test_reset_mid();
    test_rw_conflict();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported, variable-latency unified memory between the instruction-fetch stage and the memory stage of the 5-stage MIPS pipeline. The memory-stage request comes directly from the EXE/MEM pipeline register outputs (mem_read, mem_write, address, write data). The block sequences each access with a req/ready handshake and drives per-port stall signals so the pipeline holds until its access completes. Read data is returned through registered per-port data outputs.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, reset asynchronous and active-low (rst low = reset)
- if_req  in  1  fetch read request; held stable while if_stall=1
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid when if_done=1
- if_done  out  1  one-cycle pulse: fetch complete
- if_stall  out  1  hold IF stage
- mem_rd  in  1  data read (EXE/MEM mem_read output)
- mem_wr  in  1  data write (EXE/MEM mem_write output)
- mem_addr  in  ADDR_W  data address (EXE/MEM address output)
- mem_wdata  in  DATA_W  store data (EXE/MEM write-data output)
- mem_rdata  out  DATA_W  load word, valid when mem_done=1
- mem_done  out  1  one-cycle pulse: data access complete
- mem_stall  out  1  hold the whole pipeline
- ram_req  out  1  memory request, held until ram_ready sampled high
- ram_we  out  1  1 = write
- ram_addr  out  ADDR_W  memory address
- ram_wdata  out  DATA_W  memory write data
- ram_rdata  in  DATA_W  memory read data, valid with ram_ready
- ram_ready  in  1  memory completes the current request this cycle

## Operation
- States: IDLE, BUSY_MEM, BUSY_IF.
- Port requests: mem_any = mem_rd | mem_wr; if_any = if_req. In any cycle, a port whose done output is high is excluded from arbitration, because that request is already consumed.
- IDLE: if mem_any, latch addr/wdata/we into ram_* and go to BUSY_MEM. Else if if_any, latch if_addr with we=0 and go to BUSY_IF. ram_req rises on the same edge.
- mem_rd and mem_wr both high is treated as a write.
- BUSY_x: ram_req and ram_* are held constant. On the edge where ram_ready=1:
  - For a read, capture ram_rdata into x_rdata.
  - Set x_done for exactly one cycle.
  - Re-arbitrate with fairness. After BUSY_MEM, a pending IF request is granted directly (BUSY_IF, ram_req stays high with new fields). After BUSY_IF, a pending MEM request is granted directly. Otherwise go to IDLE and drop ram_req.
- Writes do not change mem_rdata. x_rdata holds its last value between transactions.
- if_stall = if_any & ~if_done; mem_stall = mem_any & ~mem_done. Both are combinational. mem_stall has priority meaning for the pipeline control: the whole pipeline freezes.
- Reset (rst low, asynchronous): state=IDLE, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, mem_rdata=0, if_done=0, mem_done=0. An in-flight request is abandoned and ram_req drops immediately. Stalls follow their combinational equations (stall = request).

## Timing
- Request first seen in IDLE at cycle 0: ram_req=1 in cycle 1. With ram_ready=1 in cycle N (N≥1), done=1 and data valid in cycle N+1, and stall deasserts in cycle N+1.
- Minimum service latency: 2 cycles request-to-done (zero-wait memory).
- Back-to-back cross-port grant: no idle cycle. ram_req stays high and fields change on the completion edge.
- Same port re-request: if the port's request is still high in the cycle after done, it is treated as a new request, arbitrated normally.
- Simultaneous MEM and IF requests in IDLE: MEM first, then IF, for a total of 2 transactions with no gap between.
- ram_ready while ram_req=0 is ignored.

## Test plan
- Zero-wait load: mem_rd=1, mem_addr=0x40, ram_ready tied 1, ram_rdata=0xDEADBEEF. Required: ram_req in cycle 1; mem_done and mem_rdata=0xDEADBEEF in cycle 2; mem_stall=1 in cycles 0–1 and 0 in cycle 2.
- Wait-state store: mem_wr=1, addr 0x80, wdata 0x12345678, ram_ready high only in cycle 4. Required: ram_we=1 and ram_addr/ram_wdata stable for cycles 1–4; mem_done in cycle 5; mem_rdata unchanged.
- Collision: if_req (addr 0x100) and mem_rd (addr 0x200) both in cycle 0, zero-wait memory. Required: ram_addr=0x200 in cycle 1 and 0x100 in cycle 2; mem_done cycle 2; if_done cycle 3; ram_req continuously high cycles 1–2.
- IF fairness: MEM and IF continuously requesting, zero-wait memory. Required: grants alternate MEM, IF, MEM, IF… and neither stall stays high longer than 4 cycles.
- Reset mid-access: rst low during BUSY_MEM with ram_ready=0. Required: ram_req=0 immediately (before the next clock edge), all outputs at reset values; after release with mem_rd still high, a fresh request is issued in cycle 1.
- Read+write conflict: mem_rd=mem_wr=1. Required: ram_we=1 and mem_rdata not updated.
